// File: rtl/matrix_vec_apply2x2.sv
// Applies a 2x2 inverse matrix to a vector (x = A_inv * y) with one shared signed multiplier over four MAC cycles.
// Optional build macro MVM_ROUND_EN selects round-half-up instead of truncation before saturation.
module matrix_vec_apply2x2 #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inv_error,
  input  logic [W-1:0] a_inv,
  input  logic [W-1:0] b_inv,
  input  logic [W-1:0] c_inv,
  input  logic [W-1:0] d_inv,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] y1,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         overflow
);

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  localparam logic signed [2*W+1:0] SAT_MAX = (2*W+2)'((64'sd1 <<< (W-1)) - 64'sd1);
  localparam logic signed [2*W+1:0] SAT_MIN = ~SAT_MAX;
`ifdef MVM_ROUND_EN
  localparam logic signed [2*W+1:0] HALF = (2*W+2)'(64'sd1 <<< (FRAC-1));
`endif

  state_t state_q, state_d;

  logic signed [W-1:0]   a_p0, b_p0, c_p0, d_p0, y0_p0, y1_p0;
  logic signed [2*W:0]   acc_p1;
  logic [1:0]            cnt;

  logic                  accept, mac_step, wr_x0, wr_x1, fin;
  logic signed [W-1:0]   op_m, op_v;
  logic signed [2*W-1:0] prod;
  logic signed [2*W:0]   prod_ext, sum;
  logic [W:0]            res;

  function automatic logic signed [2*W+1:0] round_shift(input logic signed [2*W:0] v);
    logic signed [2*W+1:0] t;
    t = {v[2*W], v};
`ifdef MVM_ROUND_EN
    t = t + HALF;
`endif
    return t >>> FRAC;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [W:0] saturate(input logic signed [2*W+1:0] v);
    if (v > SAT_MAX)
      return {1'b1, 1'b0, {(W-1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, v[W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = inv_error ? FIN : MAC;
      MAC:     if (cnt == 2'd3) state_d = IDLE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == IDLE) && start;
    mac_step = (state_q == MAC);
    wr_x0    = mac_step && (cnt == 2'd1);
    wr_x1    = mac_step && (cnt == 2'd3);
    fin      = (state_q == FIN);
  end

  // Operand select: cnt 0..3 -> a*y0, b*y1, c*y0, d*y1; odd steps close a row.
  always_comb begin
    op_m = a_p0;
    op_v = y0_p0;
    case (cnt)
      2'd0: begin op_m = a_p0; op_v = y0_p0; end
      2'd1: begin op_m = b_p0; op_v = y1_p0; end
      2'd2: begin op_m = c_p0; op_v = y0_p0; end
      2'd3: begin op_m = d_p0; op_v = y1_p0; end
      default: ;
    endcase
    prod     = op_m * op_v;
    prod_ext = {prod[2*W-1], prod};
    sum      = (cnt[0] ? acc_p1 : '0) + prod_ext;
    res      = saturate(round_shift(sum));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_p0 <= '0; b_p0 <= '0; c_p0 <= '0; d_p0 <= '0; y0_p0 <= '0; y1_p0 <= '0;
      acc_p1   <= '0;
      cnt      <= '0;
      x0       <= '0;
      x1       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_p0     <= a_inv;
        b_p0     <= b_inv;
        c_p0     <= c_inv;
        d_p0     <= d_inv;
        y0_p0    <= y0;
        y1_p0    <= y1;
        acc_p1   <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
        error    <= inv_error;
        overflow <= 1'b0;
      end
      if (mac_step) begin
        cnt    <= cnt + 2'd1;
        acc_p1 <= cnt[0] ? '0 : sum;
      end
      if (wr_x0) begin
        x0       <= res[W-1:0];
        overflow <= overflow | res[W];
      end
      if (wr_x1) begin
        x1       <= res[W-1:0];
        overflow <= overflow | res[W];
        busy     <= 1'b0;
        done     <= 1'b1;
      end
      if (fin) begin
        x0       <= '0;
        x1       <= '0;
        overflow <= 1'b0;
        error    <= 1'b1;
        busy     <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_vec_apply2x2.sv
// Directed bench for matrix_vec_apply2x2; expected rounding results follow MVM_ROUND_EN.
module tb_matrix_vec_apply2x2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        inv_error = 1'b0;
  logic [15:0] a_inv = '0, b_inv = '0, c_inv = '0, d_inv = '0, y0 = '0, y1 = '0;
  logic [15:0] x0, x1;
  logic        busy, done, error, overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  matrix_vec_apply2x2 #(.W(16), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .start(start), .inv_error(inv_error),
    .a_inv(a_inv), .b_inv(b_inv), .c_inv(c_inv), .d_inv(d_inv),
    .y0(y0), .y1(y1), .x0(x0), .x1(x1),
    .busy(busy), .done(done), .error(error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic set_inputs(input logic [15:0] a, b, c, d, v0, v1, input logic err);
    a_inv = a; b_inv = b; c_inv = c; d_inv = d; y0 = v0; y1 = v1; inv_error = err;
  endtask

  // Pulses start for one edge and returns edges from start to done (-1 if none).
  task automatic run_op(input logic [15:0] a, b, c, d, v0, v1, input logic err, output int lat);
    @(negedge clk);
    set_inputs(a, b, c, d, v0, v1, err);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inv_error = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if ({x0, x1} !== 32'h0) $display("FAIL reset_x got %h want 00000000", {x0, x1}); else pass_cnt++;
    total_cnt++; if ({busy, done, error, overflow} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, error, overflow}); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_identity();
    int lat;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0280, 16'hFF00, 1'b0, lat);
    total_cnt++; if (lat !== 4) $display("FAIL ident_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (x0 !== 16'h0280) $display("FAIL ident_x0 got %h want 0280", x0); else pass_cnt++;
    total_cnt++; if (x1 !== 16'hFF00) $display("FAIL ident_x1 got %h want ff00", x1); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ident_ovf got %b want 0", overflow); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL ident_err got %b want 0", error); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ident_busy got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL ident_done_width got %b want 0", done); else pass_cnt++;
    total_cnt++; if (x0 !== 16'h0280) $display("FAIL ident_hold_x0 got %h want 0280", x0); else pass_cnt++;
  endtask

  task automatic test_mixed();
    int lat;
    run_op(16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0100, 16'h0100, 1'b0, lat);
    total_cnt++; if (lat !== 4) $display("FAIL mixed_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (x0 !== 16'h0280) $display("FAIL mixed_x0 got %h want 0280", x0); else pass_cnt++;
    total_cnt++; if (x1 !== 16'h0000) $display("FAIL mixed_x1 got %h want 0000", x1); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mixed_ovf got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int lat;
    run_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, lat);
    total_cnt++; if (x0 !== 16'h7FFF) $display("FAIL satpos_x0 got %h want 7fff", x0); else pass_cnt++;
    total_cnt++; if (x1 !== 16'h7FFF) $display("FAIL satpos_x1 got %h want 7fff", x1); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL satpos_ovf got %b want 1", overflow); else pass_cnt++;
    run_op(16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, lat);
    total_cnt++; if (x0 !== 16'h8000) $display("FAIL satneg_x0 got %h want 8000", x0); else pass_cnt++;
    total_cnt++; if (x1 !== 16'h0000) $display("FAIL satneg_x1 got %h want 0000", x1); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL satneg_ovf got %b want 1", overflow); else pass_cnt++;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0001, 16'h0001, 1'b0, lat);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_rounding();
    int lat;
    logic [15:0] exp_x0;
`ifdef MVM_ROUND_EN
    exp_x0 = 16'h0001;
`else
    exp_x0 = 16'h0000;
`endif
    run_op(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 1'b0, lat);
    total_cnt++; if (x0 !== exp_x0) $display("FAIL round_x0 got %h want %h", x0, exp_x0); else pass_cnt++;
    total_cnt++; if (x1 !== 16'h0000) $display("FAIL round_x1 got %h want 0000", x1); else pass_cnt++;
  endtask

  task automatic test_error_path();
    int lat;
    run_op(16'h1234, 16'h0456, 16'h0789, 16'h0ABC, 16'h0100, 16'h0200, 1'b1, lat);
    total_cnt++; if (lat !== 1) $display("FAIL err_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if ({x0, x1} !== 32'h0) $display("FAIL err_x got %h want 00000000", {x0, x1}); else pass_cnt++;
    total_cnt++; if (error !== 1'b1) $display("FAIL err_flag got %b want 1", error); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL err_ovf got %b want 0", overflow); else pass_cnt++;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0300, 16'h0100, 1'b0, lat);
    total_cnt++; if (error !== 1'b0) $display("FAIL err_clear got %b want 0", error); else pass_cnt++;
    total_cnt++; if (x0 !== 16'h0300) $display("FAIL err_next_x0 got %h want 0300", x0); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    @(negedge clk);
    set_inputs(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0280, 16'hFF00, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL ign_busy got %b want 1", busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL ign_done_count got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (x1 !== 16'hFF00) $display("FAIL ign_x1 got %h want ff00", x1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    @(negedge clk);
    set_inputs(16'h0200, 16'h0000, 16'h0000, 16'h0200, 16'h0100, 16'h0100, 1'b0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    total_cnt++; if ({x0, x1} !== 32'h0) $display("FAIL rstmid_x got %h want 00000000", {x0, x1}); else pass_cnt++;
    total_cnt++; if ({busy, done, error, overflow} !== 4'b0) $display("FAIL rstmid_flags got %b want 0000", {busy, done, error, overflow}); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    total_cnt++; if (done_cnt !== 0) $display("FAIL rstmid_done_count got %0d want 0", done_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1, t3 = -1;
    @(negedge clk);
    set_inputs(16'h0200, 16'h0080, 16'hFF00, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
        else if (t3 < 0) t3 = k;
      end
    end
    start = 1'b0;
    total_cnt++; if (t1 !== 5) $display("FAIL b2b_first got %0d want 5", t1); else pass_cnt++;
    total_cnt++; if (t2 - t1 !== 5) $display("FAIL b2b_gap1 got %0d want 5", t2 - t1); else pass_cnt++;
    total_cnt++; if (t3 - t2 !== 5) $display("FAIL b2b_gap2 got %0d want 5", t3 - t2); else pass_cnt++;
    repeat (8) @(posedge clk);
    #1;
    total_cnt++; if (x0 !== 16'h0280) $display("FAIL b2b_x0 got %h want 0280", x0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_drain_busy got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_mixed();
    test_saturation();
    test_rounding();
    test_error_path();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
